// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch core.
//   - BCD digit width, seconds limit and default minutes limit
//   - run-state enum used by the pause/resume state machine
//   - active-low 7-segment patterns {g,f,e,d,c,b,a} for digits 0-9 and blank
//   - small BCD helpers for the two-digit minute/second counters
package stopwatch_pkg;

    localparam int BCD_W       = 4;
    localparam int SEC_MAX     = 59;
    localparam int MAX_MIN_DEF = 59;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } run_state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Integer 0..99 to a {tens, ones} BCD pair; used for elaboration-time limits.
    function automatic logic [2*BCD_W-1:0] to_bcd(input int n);
        logic [BCD_W-1:0] t;
        logic [BCD_W-1:0] o;
        t = BCD_W'(n / 10);
        o = BCD_W'(n % 10);
        return {t, o};
    endfunction

    // Two-digit BCD increment that wraps to 00 after reaching lim.
    function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [2*BCD_W-1:0] v,
                                                   input logic [2*BCD_W-1:0] lim);
        if (v == lim)
            return '0;
        else if (v[BCD_W-1:0] == BCD_W'(9))
            return {v[2*BCD_W-1:BCD_W] + BCD_W'(1), BCD_W'(0)};
        else
            return {v[2*BCD_W-1:BCD_W], v[BCD_W-1:0] + BCD_W'(1)};
    endfunction

endpackage

// File: rtl/stopwatch_core_sevenseg.sv
// sevenseg_decode: combinational BCD to active-low 7-segment decoder.
//   bcd : 4-bit BCD digit in
//   seg : active-low segments {g,f,e,d,c,b,a}; codes 10-15 drive all segments off
module sevenseg_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS stopwatch with pause/resume, field adjust and a
// 4-digit multiplexed 7-segment display.
//   clk       : 100 MHz master clock
//   reset     : synchronous active-high reset
//   clk_1hz   : 1 Hz square wave, counts time in RUN
//   clk_2hz   : 2 Hz square wave, steps the selected field in adjust mode
//   fast_clk  : display multiplex square wave
//   blink_clk : blink square wave for the field being adjusted
//   pause     : single-cycle pause/resume pulse
//   adj       : 1 = adjust mode
//   sel       : adjust target, 0 = minutes, 1 = seconds
//   seg       : registered active-low segments {g,f,e,d,c,b,a}
//   an        : registered active-low one-hot anodes, an[0] = seconds ones
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = MAX_MIN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       fast_clk,
    input  logic       blink_clk,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [7:0] SEC_LIM = to_bcd(SEC_MAX);
    localparam logic [7:0] MIN_LIM = to_bcd(MAX_MIN);

    // ---------------- divider edge detect ----------------
    logic       s_1hz, s_2hz, s_fast, s_blink;
    // armed[i] goes high once the input has been seen low since reset, so a
    // divider that is already high when reset releases does not count as an edge.
    logic [2:0] armed;
    logic       tick_1hz, tick_2hz, tick_fast;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_1hz   <= 1'b0;
            s_2hz   <= 1'b0;
            s_fast  <= 1'b0;
            s_blink <= 1'b0;
            armed   <= 3'b000;
        end else begin
            s_1hz   <= clk_1hz;
            s_2hz   <= clk_2hz;
            s_fast  <= fast_clk;
            s_blink <= blink_clk;
            armed   <= armed | ~{fast_clk, clk_2hz, clk_1hz};
        end
    end

    assign tick_1hz  = clk_1hz  & ~s_1hz  & armed[0];
    assign tick_2hz  = clk_2hz  & ~s_2hz  & armed[1];
    assign tick_fast = fast_clk & ~s_fast & armed[2];

    // ---------------- run/pause FSM ----------------
    run_state_t state, state_next;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (pause)
            state_next = (state == RUN) ? PAUSED : RUN;
    end

    // ---------------- BCD time counters ----------------
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic [7:0] sec_inc, min_inc;

    assign sec_inc = bcd_inc({sec_t, sec_o}, SEC_LIM);
    assign min_inc = bcd_inc({min_t, min_o}, MIN_LIM);

    // Ticks use the registered state, so a pause arriving with a tick sees the
    // pre-toggle state.
    always_ff @(posedge clk) begin
        if (reset) begin
            {min_t, min_o} <= 8'h00;
            {sec_t, sec_o} <= 8'h00;
        end else if (!adj) begin
            if (tick_1hz && state == RUN) begin
                {sec_t, sec_o} <= sec_inc;
                if ({sec_t, sec_o} == SEC_LIM)
                    {min_t, min_o} <= min_inc;
            end
        end else if (tick_2hz) begin
            // Adjust steps one field only; no carry between fields.
            if (sel) {sec_t, sec_o} <= sec_inc;
            else     {min_t, min_o} <= min_inc;
        end
    end

    // ---------------- display multiplex ----------------
    logic [1:0] idx;
    logic [3:0] digit;
    logic [6:0] seg_d;
    logic [3:0] an_d;
    logic       blank;

    always_ff @(posedge clk) begin
        if (reset)          idx <= 2'd0;
        else if (tick_fast) idx <= idx + 2'd1;
    end

    always_comb begin
        digit = sec_o;
        case (idx)
            2'd0: digit = sec_o;
            2'd1: digit = sec_t;
            2'd2: digit = min_o;
            2'd3: digit = min_t;
            default: digit = sec_o;
        endcase
    end

    sevenseg_decode u_dec (
        .bcd (digit),
        .seg (seg_d)
    );

    // Digits 3:2 are minutes, 1:0 seconds; blank the field being adjusted.
    assign blank = adj && s_blink && (sel ? !idx[1] : idx[1]);
    assign an_d  = blank ? 4'b1111 : ~(4'b0001 << idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1110;
            seg <= SEG_0;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset, clk_1hz, clk_2hz, fast_clk, blink_clk, pause, adj, sel;
    logic [6:0] seg;
    logic [3:0] an;

    int         passed = 0;
    int         total  = 0;
    logic [1:0] exp_idx;

    always #5 clk = ~clk;

    stopwatch_core #(.MAX_MIN(59)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_1hz   (clk_1hz),
        .clk_2hz   (clk_2hz),
        .fast_clk  (fast_clk),
        .blink_clk (blink_clk),
        .pause     (pause),
        .adj       (adj),
        .sel       (sel),
        .seg       (seg),
        .an        (an)
    );

    // Hand table of active-low {g,f,e,d,c,b,a} patterns.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected segments packed by digit position, position 3 (min tens) on top.
    function automatic logic [27:0] exp_segs(input int mt, input int mo, input int st, input int so);
        return {seg_of(mt), seg_of(mo), seg_of(st), seg_of(so)};
    endfunction

    task automatic pulse_1hz(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) clk_1hz = 1'b1;
            repeat (2) @(negedge clk);
            clk_1hz = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulse_2hz(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) clk_2hz = 1'b1;
            repeat (2) @(negedge clk);
            clk_2hz = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    // One fast tick; on return an/seg show the newly indexed digit.
    task automatic fast_tick();
        @(negedge clk) fast_clk = 1'b1;
        repeat (2) @(negedge clk);
        fast_clk = 1'b0;
        @(negedge clk);
        exp_idx = exp_idx + 2'd1;
    endtask

    // Scan all four digits, packing what was observed by expected position.
    task automatic scan(output logic [27:0] segs, output logic [15:0] ans);
        segs = '0;
        ans  = '0;
        for (int k = 0; k < 4; k++) begin
            fast_tick();
            segs[7*exp_idx +: 7] = seg;
            ans[4*exp_idx +: 4]  = an;
        end
    endtask

    task automatic test_reset();
        logic [27:0] s;
        logic [15:0] a;
        clk_1hz = 0; clk_2hz = 0; fast_clk = 0; blink_clk = 0;
        pause = 0; adj = 0; sel = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (an !== 4'b1110 || seg !== 7'h40)
            $display("FAIL reset_out: an=%b seg=%h expected an=1110 seg=40", an, seg);
        else passed++;
        reset = 1'b0;
        exp_idx = 2'd0;
        @(negedge clk);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,0) || a !== 16'h7BDE)
            $display("FAIL reset_time: seg=%h an=%h expected seg=%h an=7bde", s, a, exp_segs(0,0,0,0));
        else passed++;
    endtask

    task automatic test_count();
        logic [27:0] s;
        logic [15:0] a;
        pulse_1hz(61);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,1,0,1) || a !== 16'h7BDE)
            $display("FAIL count_61: seg=%h an=%h expected seg=%h an=7bde", s, a, exp_segs(0,1,0,1));
        else passed++;
    endtask

    task automatic test_preload_wrap();
        logic [27:0] s;
        logic [15:0] a;
        adj = 1; sel = 0;
        pulse_2hz(58);
        sel = 1;
        pulse_2hz(58);
        adj = 0;
        scan(s, a);
        total++;
        if (s !== exp_segs(5,9,5,9) || a !== 16'h7BDE)
            $display("FAIL preload_5959: seg=%h an=%h expected seg=%h", s, a, exp_segs(5,9,5,9));
        else passed++;
        pulse_1hz(1);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,0) || a !== 16'h7BDE)
            $display("FAIL wrap_0000: seg=%h an=%h expected seg=%h", s, a, exp_segs(0,0,0,0));
        else passed++;
    endtask

    task automatic test_pause();
        logic [27:0] s;
        logic [15:0] a;
        pulse_1hz(3);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,3))
            $display("FAIL run_3: seg=%h expected %h", s, exp_segs(0,0,0,3));
        else passed++;
        @(negedge clk) pause = 1;
        @(negedge clk) pause = 0;
        pulse_1hz(5);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,3))
            $display("FAIL paused_hold: seg=%h expected %h", s, exp_segs(0,0,0,3));
        else passed++;
        // resume pulse lands on the same edge as the tick: tick sees PAUSED
        @(negedge clk) begin pause = 1; clk_1hz = 1; end
        @(negedge clk) pause = 0;
        @(negedge clk) clk_1hz = 0;
        repeat (2) @(negedge clk);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,3))
            $display("FAIL pause_tick_same: seg=%h expected %h", s, exp_segs(0,0,0,3));
        else passed++;
        pulse_1hz(1);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,4))
            $display("FAIL resumed_tick: seg=%h expected %h", s, exp_segs(0,0,0,4));
        else passed++;
    endtask

    task automatic test_adjust();
        logic [27:0] s;
        logic [15:0] a;
        adj = 1; sel = 1;
        pulse_2hz(54);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,5,8))
            $display("FAIL adj_58: seg=%h expected %h", s, exp_segs(0,0,5,8));
        else passed++;
        pulse_2hz(3);
        pulse_1hz(2);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,1))
            $display("FAIL adj_wrap_nocarry: seg=%h expected %h", s, exp_segs(0,0,0,1));
        else passed++;
        adj = 0;
        pulse_2hz(2);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,1))
            $display("FAIL run_ignores_2hz: seg=%h expected %h", s, exp_segs(0,0,0,1));
        else passed++;
        pulse_1hz(1);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,2))
            $display("FAIL run_after_adj: seg=%h expected %h", s, exp_segs(0,0,0,2));
        else passed++;
    endtask

    task automatic test_blink();
        logic [3:0] one;
        logic [3:0] exp_an;
        one = 4'b0001;
        adj = 1; sel = 0; blink_clk = 1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            fast_tick();
            exp_an = exp_idx[1] ? 4'b1111 : ~(one << exp_idx);
            total++;
            if (an !== exp_an)
                $display("FAIL blink_min idx%0d: an=%b expected %b", exp_idx, an, exp_an);
            else passed++;
        end
        blink_clk = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            fast_tick();
            exp_an = ~(one << exp_idx);
            total++;
            if (an !== exp_an)
                $display("FAIL blink_off idx%0d: an=%b expected %b", exp_idx, an, exp_an);
            else passed++;
        end
        adj = 0;
    endtask

    task automatic test_reset_mid();
        logic [27:0] s;
        logic [15:0] a;
        adj = 1; sel = 0;
        pulse_2hz(12);
        sel = 1;
        pulse_2hz(32);
        adj = 0;
        scan(s, a);
        total++;
        if (s !== exp_segs(1,2,3,4))
            $display("FAIL preset_1234: seg=%h expected %h", s, exp_segs(1,2,3,4));
        else passed++;
        // reset together with a rising 1 Hz input and a pause pulse
        @(negedge clk) begin reset = 1; clk_1hz = 1; pause = 1; end
        @(negedge clk) begin reset = 0; pause = 0; end
        exp_idx = 2'd0;
        total++;
        if (an !== 4'b1110 || seg !== 7'h40)
            $display("FAIL mid_reset_out: an=%b seg=%h expected an=1110 seg=40", an, seg);
        else passed++;
        // 1 Hz still high since before reset release: must not count
        repeat (3) @(negedge clk);
        clk_1hz = 0;
        repeat (2) @(negedge clk);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,0) || a !== 16'h7BDE)
            $display("FAIL mid_reset_time: seg=%h an=%h expected seg=%h", s, a, exp_segs(0,0,0,0));
        else passed++;
        pulse_1hz(1);
        scan(s, a);
        total++;
        if (s !== exp_segs(0,0,0,1))
            $display("FAIL mid_reset_run: seg=%h expected %h", s, exp_segs(0,0,0,1));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_count();
        test_preload_wrap();
        test_pause();
        test_adjust();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter: MAX_MIN, 59, highest minutes value before wrap to 00.
REQ-002 Clock and reset ports SHALL be: clk input 1, 100 MHz master clock; reset input 1, synchronous active-high reset.
REQ-003 Port: clk_1hz input 1, 1 Hz square wave from the clock divider.
REQ-004 Port: clk_2hz input 1, 2 Hz square wave from the clock divider, used for adjust.
REQ-005 Port: fast_clk input 1, display-multiplex square wave from the clock divider.
REQ-006 Port: blink_clk input 1, blink square wave from the clock divider.
REQ-007 Port: pause input 1, debounced single-cycle pause/resume pulse.
REQ-008 Port: adj input 1, level, 1 = adjust mode.
REQ-009 Port: sel input 1, level, adjust target: 0 = minutes, 1 = seconds.
REQ-010 Port: seg output 7, active-low segments {g,f,e,d,c,b,a}.
REQ-011 Port: an output 4, active-low one-hot digit anodes; an[0] = seconds ones.

Function
REQ-012 Each divider input SHALL be registered once; its tick SHALL be a one-cycle pulse when the current sample is 1 and the previous sample is 0.
REQ-013 The run state machine SHALL have two states: RUN and PAUSED; a pause pulse toggles the state.
REQ-014 Time SHALL be held as four BCD digits: min_t, min_o, sec_t, sec_o.
REQ-015 When adj=0, a 1 Hz tick, and RUN: seconds increment; 59 -> 00 carries +1 minute; minutes MAX_MIN -> 00; 59:59 -> 00:00.
REQ-016 When adj=0: 2 Hz ticks ignored; time frozen in PAUSED.
REQ-017 When adj=1: 1 Hz ticks ignored; each 2 Hz tick increments the selected field by 1 regardless of run state; wrap 59 -> 00 with no carry into the other field.
REQ-018 Simultaneous pause pulse and tick: the tick SHALL be evaluated with the pre-toggle state; the new state applies from the next cycle.
REQ-019 Changes on adj/sel SHALL take effect on the next tick; no time change on a mode edge itself.
REQ-020 Digit index (2 bits) SHALL advance 0->1->2->3->0 on each fast_clk tick.
REQ-021 an SHALL select the indexed digit and seg SHALL show its BCD value; both SHALL be registered, one cycle after index update.
REQ-022 When adj=1 and registered blink_clk=1, the anodes of the selected field's two digits SHALL be forced high (blanked); the other field is unaffected.
REQ-023 BCD values 10-15 (unreachable) SHALL decode to all segments off (7'h7F).
REQ-024 No output SHALL be combinationally dependent on any input.

Reset
REQ-025 On reset=1 at a clk edge: time 00:00, state RUN, digit index 0, input sample registers 0.
REQ-026 Reset output values: an=4'b1110, seg=7'h40 (digit 0).
REQ-027 Reset SHALL take priority over ticks and pause in the same cycle; asserting it mid-count discards the count.
REQ-028 The first tick after reset SHALL require a 0->1 transition seen after reset deassertion.

Structure
REQ-029 Package stopwatch_pkg SHALL hold: BCD digit width (4), seconds max (59), MAX_MIN default, run-state enum {RUN, PAUSED}, 7-segment constants for digits 0-9 and blank.
REQ-030 One sub-module, sevenseg_decode (BCD -> active-low segments, combinational), SHALL be instantiated once after the digit mux.
REQ-031 Edge detect, BCD counters, FSM, and the display mux SHALL reside in stopwatch_core.

Verification
REQ-032 Reset, then 61 clk_1hz rising edges, adj=0 -> time 01:01; no increment on falling edges.
REQ-033 Preload 59:59 via adjust, then one 1 Hz tick in RUN -> 00:00.
REQ-034 Pause pulse, then 5 1 Hz ticks -> time unchanged. Second pause pulse and tick in the same cycle -> no increment that cycle; next tick increments.
REQ-035 adj=1, sel=1, seconds=58, three 2 Hz ticks -> seconds 01, minutes unchanged; 1 Hz ticks ignored.
REQ-036 adj=1, sel=0, blink_clk=1 -> an[3] and an[2] never low during four fast ticks; an[1:0] scan normally; blink_clk=0 -> all four scan.
REQ-037 Reset asserted mid-count at 12:34 -> next cycle 00:00, an=1110, seg=7'h40, state RUN.
